// File: rtl/simd_mem_pkg.sv
// simd_mem_pkg: shared widths and types for the SIMD vector memory read path
package simd_mem_pkg;
    localparam int ADDR_W = 12;
    localparam int SIZE = 32;
    localparam int FETCH = 4;
    localparam int CNT_W = 8;
    typedef logic [SIZE-1:0][FETCH-1:0] vec_t;
    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] stride;
        logic [CNT_W-1:0] count;
    } fetch_cmd_t;
    typedef enum logic {IDLE, RUN} fetch_state_e;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that clears on i_rst and sticks at all-ones
module sat_counter #(
    parameter int W = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);
    always_ff @(posedge i_clk) begin
        if (i_rst) o_count <= '0;
        else if (i_inc && !(&o_count)) o_count <= o_count + 1'b1;
    end
endmodule

// File: rtl/vec_fetch_unit.sv
// vec_fetch_unit: strided vector read sequencer; VEC_FETCH_PERF_EN adds handshake/stall counters
module vec_fetch_unit
    import simd_mem_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cmd_valid,
    output logic              o_cmd_ready,
    input  logic [ADDR_W-1:0] i_cmd_base,
    input  logic [ADDR_W-1:0] i_cmd_stride,
    input  logic [CNT_W-1:0]  i_cmd_count,
    output logic [ADDR_W-1:0] o_mem_addr_r,
    input  vec_t              i_mem_data,
    output logic              o_vec_valid,
    input  logic              i_vec_ready,
    output vec_t              o_vec_data,
    output logic              o_vec_last,
    output logic              o_busy
`ifdef VEC_FETCH_PERF_EN
    ,
    output logic [31:0]       o_perf_vecs,
    output logic [31:0]       o_perf_stalls
`endif
);
    fetch_state_e state_q, state_d;
    fetch_cmd_t cmd_q;
    logic load;
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        o_cmd_ready = state_q == IDLE;
        load = state_q == RUN && (!o_vec_valid || i_vec_ready);
        state_d = o_cmd_ready ? ((i_cmd_valid && i_cmd_count != '0) ? RUN : IDLE)
                              : ((load && cmd_q.count == CNT_W'(1)) ? IDLE : RUN);
    end
    // cmd_q.base doubles as the live read address, cmd_q.count as the remaining vectors
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cmd_q <= '0;
            o_vec_valid <= 1'b0;
            o_vec_last <= 1'b0;
            o_vec_data <= '0;
        end else begin
            if (o_cmd_ready && i_cmd_valid) begin
                cmd_q <= '{base: i_cmd_base, stride: i_cmd_stride, count: i_cmd_count};
            end else if (load) begin
                cmd_q.base <= cmd_q.base + cmd_q.stride;
                cmd_q.count <= cmd_q.count - 1'b1;
            end
            if (load) begin
                o_vec_data <= i_mem_data;
                o_vec_valid <= 1'b1;
                o_vec_last <= cmd_q.count == CNT_W'(1);
            end else if (o_vec_valid && i_vec_ready) begin
                o_vec_valid <= 1'b0;
            end
        end
    end
    assign o_mem_addr_r = cmd_q.base;
    assign o_busy = state_q == RUN || o_vec_valid;
`ifdef VEC_FETCH_PERF_EN
    sat_counter #(.W(32)) u_perf_vecs (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(o_vec_valid && i_vec_ready), .o_count(o_perf_vecs)
    );
    sat_counter #(.W(32)) u_perf_stalls (
        .i_clk(i_clk), .i_rst(i_rst), .i_inc(o_vec_valid && !i_vec_ready), .o_count(o_perf_stalls)
    );
`endif
endmodule

// File: tb/tb_vec_fetch_unit.sv
// tb_vec_fetch_unit: directed checks of command sequencing, backpressure, wrap and reset
module tb_vec_fetch_unit;
    import simd_mem_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_ready;
    logic [ADDR_W-1:0] cmd_base = '0;
    logic [ADDR_W-1:0] cmd_stride = '0;
    logic [CNT_W-1:0] cmd_count = '0;
    logic [ADDR_W-1:0] mem_addr;
    vec_t mem_data;
    logic vec_valid;
    logic vec_ready = 1'b1;
    vec_t vec_data;
    logic vec_last;
    logic busy;
    int total = 0;
    int bad = 0;
`ifdef VEC_FETCH_PERF_EN
    logic [31:0] perf_vecs, perf_stalls;
`endif

    always #5 clk = ~clk;

    function automatic vec_t mem_word(input logic [ADDR_W-1:0] a);
        return {32'hA000_0000 | 32'(a), 32'hB000_0000 | 32'(a), 32'hC000_0000 | 32'(a), 32'hD000_0000 | 32'(a)};
    endfunction

    assign mem_data = mem_word(mem_addr);

    vec_fetch_unit dut (
        .i_clk(clk), .i_rst(rst),
        .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
        .i_cmd_base(cmd_base), .i_cmd_stride(cmd_stride), .i_cmd_count(cmd_count),
        .o_mem_addr_r(mem_addr), .i_mem_data(mem_data),
        .o_vec_valid(vec_valid), .i_vec_ready(vec_ready),
        .o_vec_data(vec_data), .o_vec_last(vec_last), .o_busy(busy)
`ifdef VEC_FETCH_PERF_EN
        , .o_perf_vecs(perf_vecs), .o_perf_stalls(perf_stalls)
`endif
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] s, input logic [CNT_W-1:0] c);
        cmd_valid = 1'b1;
        cmd_base = b;
        cmd_stride = s;
        cmd_count = c;
        step;
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        step;
        step;
        total++;
        if ({cmd_ready, vec_valid, vec_last, busy} !== 4'b1000 || vec_data !== '0 || mem_addr !== '0) begin
            bad++;
            $display("FAIL reset: ready/valid/last/busy=%b data=%h addr=%h expected 1000 0 0",
                     {cmd_ready, vec_valid, vec_last, busy}, vec_data, mem_addr);
        end
        rst = 1'b0;
        step;
    endtask

    task automatic test_basic;
        logic [ADDR_W-1:0] a;
        vec_ready = 1'b1;
        issue(12'h010, 12'h004, 8'd3);
        total++;
        if (mem_addr !== 12'h010 || vec_valid !== 1'b0 || cmd_ready !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL basic_t1: addr=%h valid=%b ready=%b busy=%b expected 010 0 0 1", mem_addr, vec_valid, cmd_ready, busy);
        end
        for (int i = 0; i < 3; i++) begin
            step;
            a = 12'h010 + 12'(4 * i);
            total++;
            if (vec_valid !== 1'b1 || vec_data !== mem_word(a) || vec_last !== (i == 2) || cmd_ready !== (i == 2)) begin
                bad++;
                $display("FAIL basic_beat%0d: valid=%b data=%h last=%b cmd_ready=%b expected 1 %h %b %b",
                         i + 1, vec_valid, vec_data, vec_last, cmd_ready, mem_word(a), i == 2, i == 2);
            end
        end
        step;
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL basic_end: valid=%b busy=%b cmd_ready=%b expected 0 0 1", vec_valid, busy, cmd_ready);
        end
    endtask

    task automatic test_stall;
        rst = 1'b1;
        step;
        rst = 1'b0;
        vec_ready = 1'b1;
        issue(12'h010, 12'h004, 8'd3);
        step;
        vec_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            total++;
            if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h010) || vec_last !== 1'b0 || mem_addr !== 12'h014) begin
                bad++;
                $display("FAIL stall_hold%0d: valid=%b data=%h last=%b addr=%h expected 1 %h 0 014",
                         k, vec_valid, vec_data, vec_last, mem_addr, mem_word(12'h010));
            end
            step;
        end
        vec_ready = 1'b1;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h010)) begin
            bad++;
            $display("FAIL stall_release: valid=%b data=%h expected 1 %h", vec_valid, vec_data, mem_word(12'h010));
        end
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h014) || vec_last !== 1'b0) begin
            bad++;
            $display("FAIL stall_beat2: valid=%b data=%h last=%b expected 1 %h 0", vec_valid, vec_data, vec_last, mem_word(12'h014));
        end
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h018) || vec_last !== 1'b1) begin
            bad++;
            $display("FAIL stall_beat3: valid=%b data=%h last=%b expected 1 %h 1", vec_valid, vec_data, vec_last, mem_word(12'h018));
        end
        step;
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL stall_end: valid=%b busy=%b expected 0 0", vec_valid, busy);
        end
`ifdef VEC_FETCH_PERF_EN
        total++;
        if (perf_vecs !== 32'd3 || perf_stalls !== 32'd4) begin
            bad++;
            $display("FAIL perf: vecs=%0d stalls=%0d expected 3 4", perf_vecs, perf_stalls);
        end
`endif
    endtask

    task automatic test_wrap;
        vec_ready = 1'b1;
        issue(12'hFFC, 12'h008, 8'd2);
        total++;
        if (mem_addr !== 12'hFFC) begin
            bad++;
            $display("FAIL wrap_addr0: addr=%h expected ffc", mem_addr);
        end
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'hFFC) || mem_addr !== 12'h004) begin
            bad++;
            $display("FAIL wrap_beat1: valid=%b data=%h addr=%h expected 1 %h 004", vec_valid, vec_data, mem_addr, mem_word(12'hFFC));
        end
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h004) || vec_last !== 1'b1) begin
            bad++;
            $display("FAIL wrap_beat2: valid=%b data=%h last=%b expected 1 %h 1", vec_valid, vec_data, vec_last, mem_word(12'h004));
        end
        step;
    endtask

    task automatic test_zero_count;
        issue(12'h040, 12'h004, 8'd0);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (vec_valid !== 1'b0 || cmd_ready !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL zero_count%0d: valid=%b cmd_ready=%b busy=%b expected 0 1 0", k, vec_valid, cmd_ready, busy);
            end
            step;
        end
    endtask

    task automatic test_reset_mid;
        vec_ready = 1'b1;
        issue(12'h100, 12'h010, 8'd5);
        step;
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h110)) begin
            bad++;
            $display("FAIL rstmid_beat2: valid=%b data=%h expected 1 %h", vec_valid, vec_data, mem_word(12'h110));
        end
        vec_ready = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        vec_ready = 1'b1;
        total++;
        if ({vec_valid, busy, cmd_ready, vec_last} !== 4'b0010 || mem_addr !== '0 || vec_data !== '0) begin
            bad++;
            $display("FAIL rstmid_clear: valid/busy/cmd_ready/last=%b addr=%h data=%h expected 0010 0 0",
                     {vec_valid, busy, cmd_ready, vec_last}, mem_addr, vec_data);
        end
        issue(12'h020, 12'h001, 8'd1);
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h020) || vec_last !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_restart: valid=%b data=%h last=%b cmd_ready=%b expected 1 %h 1 1",
                     vec_valid, vec_data, vec_last, cmd_ready, mem_word(12'h020));
        end
        step;
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rstmid_end: valid=%b busy=%b expected 0 0", vec_valid, busy);
        end
    endtask

    task automatic test_back_to_back;
        vec_ready = 1'b1;
        issue(12'h200, 12'h004, 8'd1);
        step;
        vec_ready = 1'b0;
        total++;
        if (vec_valid !== 1'b1 || vec_last !== 1'b1 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pending: valid=%b last=%b cmd_ready=%b expected 1 1 1", vec_valid, vec_last, cmd_ready);
        end
        issue(12'h300, 12'h004, 8'd1);
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h200) || mem_addr !== 12'h300 || busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_wait: valid=%b data=%h addr=%h busy=%b expected 1 %h 300 1",
                     vec_valid, vec_data, mem_addr, busy, mem_word(12'h200));
        end
        vec_ready = 1'b1;
        step;
        total++;
        if (vec_valid !== 1'b1 || vec_data !== mem_word(12'h300) || vec_last !== 1'b1) begin
            bad++;
            $display("FAIL b2b_second: valid=%b data=%h last=%b expected 1 %h 1", vec_valid, vec_data, vec_last, mem_word(12'h300));
        end
        step;
        total++;
        if (vec_valid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_end: valid=%b busy=%b expected 0 0", vec_valid, busy);
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_stall;
        test_wrap;
        test_zero_count;
        test_reset_mid;
        test_back_to_back;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
